uart_tx_serializer: RTL and testbench

Transmit serializer for the UART core, directly downstream of the transmit FIFO. It pops bytes from the FIFO with a one-cycle active-low read strobe and waits a fixed read latency. It then shifts each byte out on `tx` as an asynchronous frame: start bit, 7 or 8 data bits LSB first, optional parity bit and one stop bit. Bit timing comes from a x16 oversampling enable supplied by the baud generator.

---
 rtl/uart_tx_serializer.sv | 187 ++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// Pops bytes from the transmit FIFO and shifts each one out on tx as an
// asynchronous frame: start bit, 7 or 8 data bits LSB first, optional parity
// bit and one stop bit. Each bit lasts 16 pulses of the x16 baud enable.
//
// Parameters
//   RD_LAT       cycles from the fifo_read_n low cycle to valid fifo_data (1..7)
//
// Ports
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   baud16_en    one-cycle pulse at 16x the baud rate
//   fifo_empty   transmit FIFO empty flag
//   fifo_data    transmit FIFO read data
//   bit8         1: 8 data bits, 0: 7 data bits (bit 7 ignored)
//   parity_en    1: append a parity bit
//   odd_n_even   1: odd parity, 0: even parity
//   fifo_read_n  FIFO read strobe, active low, registered
//   tx           serial output, idles high, registered
//   tx_busy      high while a byte is being fetched or sent
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
   parameter int unsigned RD_LAT = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       baud16_en,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_data,
   input  logic       bit8,
   input  logic       parity_en,
   input  logic       odd_n_even,
   output logic       fifo_read_n,
   output logic       tx,
   output logic       tx_busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_PARITY = 3'd5,
      S_STOP   = 3'd6
   } state_t;

   localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

   state_t     state_q, state_d;
   logic [2:0] wait_cnt_q, wait_cnt_d;
   logic [3:0] tick_q, tick_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       bit8_q, bit8_d;
   logic       parity_en_q, parity_en_d;
   logic       parity_q, parity_d;
   logic       tx_q, tx_d;
   logic       read_n_q, read_n_d;

   logic       in_frame;
   logic       bit_end;
   logic [2:0] last_bit;
   logic [7:0] load_bits;

   // Only the serial-bit states consume baud ticks.
   assign in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
   assign bit_end   = in_frame && baud16_en && (tick_q == 4'd15);
   assign last_bit  = bit8_q ? 3'd7 : 3'd6;
   // In 7-bit mode bit 7 must not contribute to parity.
   assign load_bits = bit8 ? fifo_data : {1'b0, fifo_data[6:0]};

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      tick_d      = tick_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      bit8_d      = bit8_q;
      parity_en_d = parity_en_q;
      parity_d    = parity_q;
      tx_d        = 1'b1;
      read_n_d    = 1'b1;

      // The 4-bit tick counter wraps naturally on the 16th pulse.
      if (in_frame && baud16_en) begin
         tick_d = tick_q + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            // The FETCH cycle itself is count 0; WAIT covers counts 1..RD_LAT.
            wait_cnt_d = 3'd1;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_q == RD_LAT_C) begin
               shift_d     = fifo_data;
               bit8_d      = bit8;
               parity_en_d = parity_en;
               parity_d    = (^load_bits) ^ odd_n_even;
               tick_d      = 4'd0;
               state_d     = S_START;
            end else begin
               wait_cnt_d = wait_cnt_q + 3'd1;
            end
         end
         S_START: begin
            if (bit_end) begin
               bit_cnt_d = 3'd0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_cnt_q == last_bit) begin
                  state_d = parity_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               state_d = fifo_empty ? S_IDLE : S_FETCH;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are registered, so they are decoded from the next state.
      read_n_d = (state_d != S_FETCH);
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = parity_d;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         wait_cnt_q  <= 3'd0;
         tick_q      <= 4'd0;
         bit_cnt_q   <= 3'd0;
         shift_q     <= 8'h00;
         bit8_q      <= 1'b0;
         parity_en_q <= 1'b0;
         parity_q    <= 1'b0;
         tx_q        <= 1'b1;
         read_n_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         tick_q      <= tick_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         bit8_q      <= bit8_d;
         parity_en_q <= parity_en_d;
         parity_q    <= parity_d;
         tx_q        <= tx_d;
         read_n_q    <= read_n_d;
      end
   end

   assign tx          = tx_q;
   assign fifo_read_n = read_n_q;
   assign tx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_serializer
//
// Scoreboard bench: each byte handed to the FIFO model pushes its expected
// frame (computed from the framing rules) into exp_q. A monitor running on
// the falling clock edge detects start bits on tx, pops the expected frame
// and checks every tx cycle against the bit owed for the number of baud
// pulses seen so far in that frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_serializer;
   localparam int RD_LAT = 3;

   logic       clock      = 1'b0;
   logic       reset_n    = 1'b0;
   logic       baud16_en  = 1'b0;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data  = 8'h00;
   logic       bit8       = 1'b1;
   logic       parity_en  = 1'b0;
   logic       odd_n_even = 1'b0;
   logic       fifo_read_n;
   logic       tx;
   logic       tx_busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   uart_tx_serializer #(.RD_LAT(RD_LAT)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .baud16_en   (baud16_en),
      .fifo_empty  (fifo_empty),
      .fifo_data   (fifo_data),
      .bit8        (bit8),
      .parity_en   (parity_en),
      .odd_n_even  (odd_n_even),
      .fifo_read_n (fifo_read_n),
      .tx          (tx),
      .tx_busy     (tx_busy)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [11:0] bits;
      int          len;
      logic [7:0]  data;
   } frame_t;

   function automatic frame_t make_frame(logic [7:0] b, logic b8, logic pe, logic odd);
      frame_t f;
      int     nd;
      int     ones;
      logic   par;
      f.bits = '0;
      f.len  = 0;
      f.data = b;
      nd     = b8 ? 8 : 7;
      ones   = 0;
      f.bits[f.len] = 1'b0;
      f.len++;
      for (int i = 0; i < nd; i++) begin
         f.bits[f.len] = b[i];
         ones += int'(b[i]);
         f.len++;
      end
      if (pe) begin
         par = ((ones % 2) == 1);
         if (odd) par = !par;
         f.bits[f.len] = par;
         f.len++;
      end
      f.bits[f.len] = 1'b1;
      f.len++;
      return f;
   endfunction

   logic [7:0] fifo_q[$];
   frame_t     exp_q[$];

   task automatic send_byte(logic [7:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(make_frame(b, bit8, parity_en, odd_n_even));
   endtask

   // ---------------- checks ----------------
   task automatic check_int(string name, int got, int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, required %0d", name, got, want);
      end else begin
         $display("[TB] ok %s = %0d", name, got);
      end
   endtask

   task automatic check_bit(string name, logic got, logic want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %b, required %b", name, got, want);
      end else begin
         $display("[TB] ok %s = %b", name, got);
      end
   endtask

   // ---------------- FIFO model + monitor (one negedge process) ----------------
   int         cyc = 0;
   int         reads_seen = 0;
   logic [7:0] due_data[$];
   int         due_cyc[$];

   bit         mon_in_frame = 1'b0;
   bit         mon_err;
   bit         mon_unexp;
   int         mon_k;
   int         mon_start;
   int         mon_idx;
   frame_t     mon_f;
   logic [11:0] mon_rx;
   int         fs_q[$];
   int         fe_q[$];

   task automatic fifo_step();
      if (reset_n && fifo_read_n == 1'b0) begin
         reads_seen++;
         n_tests++;
         if (fifo_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL empty_read: fifo_read_n low at cycle %0d, required fifo non-empty", cyc);
         end else begin
            due_data.push_back(fifo_q.pop_front());
            due_cyc.push_back(cyc + RD_LAT);
         end
      end
      // Data is only valid in the cycle RD_LAT after the strobe; garbage otherwise.
      if (due_cyc.size() > 0 && due_cyc[0] == cyc) begin
         fifo_data = due_data.pop_front();
         void'(due_cyc.pop_front());
      end else begin
         fifo_data = 8'($urandom);
      end
      fifo_empty = (fifo_q.size() == 0);
   endtask

   task automatic monitor_step();
      if (!reset_n) begin
         mon_in_frame = 1'b0;
         return;
      end
      if (!mon_in_frame) begin
         if (tx !== 1'b0) return;
         mon_in_frame = 1'b1;
         mon_k        = 0;
         mon_err      = 1'b0;
         mon_unexp    = 1'b0;
         mon_start    = cyc;
         mon_rx       = '0;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
            mon_unexp = 1'b1;
            mon_f     = make_frame(8'h00, 1'b1, 1'b0, 1'b0);
         end else begin
            mon_f = exp_q.pop_front();
         end
      end
      mon_idx = mon_k / 16;
      if (tx !== mon_f.bits[mon_idx]) mon_err = 1'b1;
      if ((mon_k % 16) == 8) mon_rx[mon_idx] = tx;
      if (baud16_en) mon_k++;
      if (mon_k == 16 * mon_f.len) begin
         mon_in_frame = 1'b0;
         fs_q.push_back(mon_start);
         fe_q.push_back(cyc);
         if (!mon_unexp) begin
            n_tests++;
            if (mon_err) begin
               n_fail++;
               $display("[TB] FAIL frame_%02h: tx bits %b, required %b (len %0d)",
                        mon_f.data, mon_rx, mon_f.bits, mon_f.len);
            end else begin
               $display("[TB] frame data=%02h len=%0d cycles=%0d ok",
                        mon_f.data, mon_f.len, cyc - mon_start + 1);
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         fifo_step();
         monitor_step();
      end
   end

   // ---------------- baud enable generator ----------------
   int baud_mode = 0;   // 0 high, 1 every 4th cycle, 2 random, 3 toggle
   int baud_ph   = 0;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         baud_ph++;
         case (baud_mode)
            0:       baud16_en = 1'b1;
            1:       baud16_en = ((baud_ph % 4) == 0);
            2:       baud16_en = ($urandom_range(0, 1) == 1);
            default: baud16_en = !baud16_en;
         endcase
      end
   end

   // ---------------- sequencing helpers ----------------
   task automatic tick(int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_done(string name, int budget);
      int t = 0;
      while ((exp_q.size() != 0 || fifo_q.size() != 0 || mon_in_frame || tx_busy) && t < budget) begin
         tick();
         t++;
      end
      if (t >= budget) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL %s: not idle after %0d cycles, required completion", name, budget);
      end
   endtask

   task automatic wait_busy(string name, int budget);
      int t = 0;
      while (tx_busy !== 1'b1 && t < budget) begin
         tick();
         t++;
      end
      if (t >= budget) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL %s: tx_busy never rose within %0d cycles", name, budget);
      end
   endtask

   task automatic wait_tx_low(string name, int budget);
      int t = 0;
      while (tx !== 1'b0 && t < budget) begin
         tick();
         t++;
      end
      if (t >= budget) begin
         n_tests++;
         n_fail++;
         $display("[TB] FAIL %s: tx never went low within %0d cycles", name, budget);
      end
   endtask

   task automatic set_cfg(logic b8, logic pe, logic odd);
      bit8       = b8;
      parity_en  = pe;
      odd_n_even = odd;
   endtask

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int r0;
      int busy_len;
      int drops;
      int t;
      int bad;
      int dur;

      reset_n = 1'b0;
      tick(3);
      check_bit("reset_tx", tx, 1'b1);
      check_bit("reset_read_n", fifo_read_n, 1'b1);
      check_bit("reset_busy", tx_busy, 1'b0);
      reset_n = 1'b1;
      tick(2);

      // 8N1, baud tied high, single 0x55
      baud_mode = 0;
      set_cfg(1'b1, 1'b0, 1'b0);
      fs_q.delete(); fe_q.delete();
      r0 = reads_seen;
      send_byte(8'h55);
      wait_busy("busy_rise_55", 50);
      check_bit("read_strobe_with_busy", fifo_read_n, 1'b0);
      busy_len = 0;
      while (tx_busy && busy_len < 400) begin
         busy_len++;
         tick();
      end
      check_int("busy_len_8n1", busy_len, 4 + 160);
      check_int("read_pulses_55", reads_seen - r0, 1);
      wait_done("done_55", 100);
      check_int("frame_count_55", fe_q.size(), 1);
      if (fe_q.size() == 1) check_int("frame_cycles_55", fe_q[0] - fs_q[0] + 1, 160);

      // 7 data bits with parity; 0xC1 must match 0x41
      fs_q.delete(); fe_q.delete();
      set_cfg(1'b0, 1'b1, 1'b0);
      send_byte(8'h41);
      wait_done("done_41e", 500);
      set_cfg(1'b0, 1'b1, 1'b1);
      send_byte(8'h41);
      wait_done("done_41o", 500);
      set_cfg(1'b0, 1'b1, 1'b0);
      send_byte(8'hC1);
      wait_done("done_c1e", 500);
      check_int("frame_count_7p", fe_q.size(), 3);
      if (fe_q.size() == 3) check_int("frame_cycles_7p", fe_q[2] - fs_q[2] + 1, 160);

      // Back-to-back 0x01, 0x80, 0xFF, 8N1
      fs_q.delete(); fe_q.delete();
      set_cfg(1'b1, 1'b0, 1'b0);
      r0 = reads_seen;
      send_byte(8'h01);
      send_byte(8'h80);
      send_byte(8'hFF);
      wait_busy("busy_rise_b2b", 50);
      drops = 0;
      t = 0;
      while (fe_q.size() < 3 && t < 1000) begin
         if (!tx_busy) drops++;
         tick();
         t++;
      end
      check_int("busy_drops_b2b", drops, 0);
      wait_done("done_b2b", 200);
      check_int("read_pulses_b2b", reads_seen - r0, 3);
      check_int("frame_count_b2b", fe_q.size(), 3);
      if (fe_q.size() == 3) begin
         check_int("gap_b2b_1", fs_q[1] - fe_q[0] - 1, 1 + RD_LAT);
         check_int("gap_b2b_2", fs_q[2] - fe_q[1] - 1, 1 + RD_LAT);
      end

      // Empty FIFO, toggling baud enable
      baud_mode = 3;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         if (fifo_read_n !== 1'b1 || tx !== 1'b1 || tx_busy !== 1'b0) bad++;
         tick();
      end
      check_int("idle_bad_cycles", bad, 0);

      // Reset during data bit 3, then a fresh frame
      baud_mode = 0;
      set_cfg(1'b1, 1'b0, 1'b0);
      send_byte(8'hA5);
      wait_tx_low("start_a5", 50);
      tick(16 + 3 * 16 + 8);
      #2;
      reset_n = 1'b0;
      #1;
      check_bit("async_reset_tx", tx, 1'b1);
      check_bit("async_reset_busy", tx_busy, 1'b0);
      tick(3);
      reset_n = 1'b1;
      tick(2);
      r0 = reads_seen;
      send_byte(8'h3C);
      wait_done("done_after_reset", 500);
      check_int("read_pulses_after_reset", reads_seen - r0, 1);

      // 8E1, one baud pulse every 4 cycles, byte 0x03
      fs_q.delete(); fe_q.delete();
      baud_mode = 1;
      set_cfg(1'b1, 1'b1, 1'b0);
      send_byte(8'h03);
      wait_done("done_03", 3000);
      check_int("frame_count_03", fe_q.size(), 1);
      if (fe_q.size() == 1) begin
         dur = fe_q[0] - fs_q[0] + 1;
         // Only the start bit may be shortened by the pulse phase.
         check_int("frame_cycles_03_in_range", int'(dur >= 11 * 64 - 3 && dur <= 11 * 64), 1);
      end

      // Config changes mid-frame must not affect the frame in flight
      baud_mode = 0;
      set_cfg(1'b1, 1'b0, 1'b0);
      send_byte(8'hB4);
      wait_tx_low("start_b4", 50);
      tick(20);
      set_cfg(1'b0, 1'b1, 1'b1);
      wait_done("done_b4", 500);

      // Randomized batches
      for (int batch = 0; batch < 8; batch++) begin
         baud_mode = $urandom_range(0, 2);
         set_cfg(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int j = 0; j < 5; j++) begin
            send_byte(8'($urandom));
            tick($urandom_range(1, 200));
         end
         wait_done("done_random", 20000);
      end

      check_int("expected_frames_left", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
